// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
interface fetch_unit_if;
   localparam int unsigned XLEN = 32;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with a one-entry skid buffer and
// redirect handling that drains an in-flight request before refetching.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_unit_if.master      imem,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [31:0]       instruccion,
   output logic              inst_valid,
   output logic [31:0]       pc_out
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {S_FETCH, S_FULL, S_DROP} state_t;

   state_t          r_state;
   logic            r_req;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_pend_pc;
   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_pc_out;
   logic            r_valid;
   logic [XLEN-1:0] r_skid_inst;
   logic [XLEN-1:0] r_skid_pc;
   logic            r_skid_valid;

   logic            w_ack;
   logic            w_consume;
   logic [XLEN-1:0] w_target;

   assign w_ack     = r_req & imem.imem_ack;
   assign w_consume = r_valid & ~stall;
   assign w_target  = redirect_pc & ~XLEN'(32'h3);

   assign imem.imem_req  = r_req;
   assign imem.imem_addr = r_addr;
   assign instruccion    = r_inst;
   assign inst_valid     = r_valid;
   assign pc_out         = r_pc_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_FETCH;
         r_req        <= 1'b0;
         r_addr       <= RESET_PC;
         r_pend_pc    <= RESET_PC;
         r_inst       <= '0;
         r_pc_out     <= '0;
         r_valid      <= 1'b0;
         r_skid_inst  <= '0;
         r_skid_pc    <= '0;
         r_skid_valid <= 1'b0;
      end else begin
         if (w_consume) r_valid <= 1'b0;

         // Redirect wins over stall and any same-cycle response.
         if (redirect) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            if (r_state != S_FULL && r_req && !imem.imem_ack) begin
               r_state   <= S_DROP;
               r_pend_pc <= w_target;
            end else begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
               r_addr  <= w_target;
            end
         end else begin
            case (r_state)
               S_FETCH: begin
                  r_req <= 1'b1;
                  if (w_ack) begin
                     r_addr <= r_addr + XLEN'(PC_STEP);
                     if (!r_valid || w_consume) begin
                        r_inst   <= imem.imem_rdata;
                        r_pc_out <= r_addr;
                        r_valid  <= 1'b1;
                     end else begin
                        r_skid_inst  <= imem.imem_rdata;
                        r_skid_pc    <= r_addr;
                        r_skid_valid <= 1'b1;
                        r_state      <= S_FULL;
                        r_req        <= 1'b0;
                     end
                  end
               end
               S_FULL: begin
                  if (w_consume) begin
                     r_inst       <= r_skid_inst;
                     r_pc_out     <= r_skid_pc;
                     r_valid      <= 1'b1;
                     r_skid_valid <= 1'b0;
                     r_state      <= S_FETCH;
                     r_req        <= 1'b1;
                  end
               end
               S_DROP: begin
                  // Stale response is swallowed; resume at the pending target.
                  if (w_ack) begin
                     r_state <= S_FETCH;
                     r_req   <= 1'b1;
                     r_addr  <= r_pend_pc;
                  end
               end
               default: r_state <= S_FETCH;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/skid, redirect/drop,
// redirect over a full skid, reset mid-request and PC wrap-around.
module tb_fetch_unit;
   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instruccion;
   logic        inst_valid;
   logic [31:0] pc_out;

   logic        zw;       // 1: memory answers in the same cycle as the request
   logic        man_ack;  // ack used when zw = 0

   logic        stall2;
   logic        redirect2;
   logic [31:0] redirect_pc2;
   logic [31:0] instruccion2;
   logic        inst_valid2;
   logic [31:0] pc_out2;

   int checks;
   int errs;

   fetch_unit_if imem_if ();
   fetch_unit_if imem_if2 ();

   assign imem_if.imem_ack    = zw ? imem_if.imem_req : man_ack;
   assign imem_if.imem_rdata  = imem_if.imem_addr + 32'h100;
   assign imem_if2.imem_ack   = imem_if2.imem_req;
   assign imem_if2.imem_rdata = imem_if2.imem_addr + 32'h100;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (imem_if.master),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instruccion (instruccion),
      .inst_valid  (inst_valid),
      .pc_out      (pc_out)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (imem_if2.master),
      .stall       (stall2),
      .redirect    (redirect2),
      .redirect_pc (redirect_pc2),
      .instruccion (instruccion2),
      .inst_valid  (inst_valid2),
      .pc_out      (pc_out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks       = 0;
      errs         = 0;
      rst_n        = 1'b0;
      stall        = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = '0;
      zw           = 1'b1;
      man_ack      = 1'b0;
      stall2       = 1'b0;
      redirect2    = 1'b0;
      redirect_pc2 = '0;

      step(); step();
      chk("rst_req",   32'(imem_if.imem_req), 32'd0);
      chk("rst_addr",  imem_if.imem_addr, 32'h0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst",  instruccion, 32'h0);
      chk("rst_pcout", pc_out, 32'h0);
      chk("rst_addr2", imem_if2.imem_addr, 32'hFFFF_FFF8);

      rst_n = 1'b1;
      step();
      chk("first_req",  32'(imem_if.imem_req), 32'd1);
      chk("first_addr", imem_if.imem_addr, 32'h0);
      chk("first_val",  32'(inst_valid), 32'd0);

      // Zero-wait streaming.
      step();
      chk("s0_valid", 32'(inst_valid), 32'd1);
      chk("s0_pc",    pc_out, 32'h0);
      chk("s0_inst",  instruccion, 32'h100);
      chk("w0_pc",    pc_out2, 32'hFFFF_FFF8);
      chk("w0_inst",  instruccion2, 32'h0000_00F8);
      step();
      chk("s1_pc",   pc_out, 32'h4);
      chk("s1_inst", instruccion, 32'h104);
      chk("w1_pc",   pc_out2, 32'hFFFF_FFFC);
      step();
      chk("s2_pc",   pc_out, 32'h8);
      chk("s2_inst", instruccion, 32'h108);
      chk("w2_pc",   pc_out2, 32'h0);
      chk("w2_val",  32'(inst_valid2), 32'd1);

      // Stall three cycles while pc_out=8: skid captures 12.
      stall = 1'b1;
      step();
      chk("st1_pc",  pc_out, 32'h8);
      chk("st1_req", 32'(imem_if.imem_req), 32'd0);
      chk("st1_val", 32'(inst_valid), 32'd1);
      step();
      chk("st2_pc",  pc_out, 32'h8);
      chk("st2_req", 32'(imem_if.imem_req), 32'd0);
      step();
      chk("st3_pc",   pc_out, 32'h8);
      chk("st3_inst", instruccion, 32'h108);
      stall = 1'b0;
      step();
      chk("sk_pc",   pc_out, 32'hC);
      chk("sk_inst", instruccion, 32'h10C);
      chk("sk_req",  32'(imem_if.imem_req), 32'd1);
      chk("sk_addr", imem_if.imem_addr, 32'h10);
      step();
      chk("sk2_pc", pc_out, 32'h10);

      // Redirect coinciding with an ack: data dropped, refetch at 4.
      redirect    = 1'b1;
      redirect_pc = 32'h4;
      step();
      chk("rd_val",  32'(inst_valid), 32'd0);
      chk("rd_addr", imem_if.imem_addr, 32'h4);
      redirect = 1'b0;
      zw       = 1'b0;
      step();
      chk("dl_addr", imem_if.imem_addr, 32'h4);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0043;
      step();
      chk("drop_addr", imem_if.imem_addr, 32'h4);
      chk("drop_req",  32'(imem_if.imem_req), 32'd1);
      chk("drop_val",  32'(inst_valid), 32'd0);
      redirect = 1'b0;
      man_ack  = 1'b1;
      step();
      chk("dack_val",  32'(inst_valid), 32'd0);
      chk("dack_addr", imem_if.imem_addr, 32'h40);
      man_ack = 1'b0;
      zw      = 1'b1;
      step();
      chk("d40_val",  32'(inst_valid), 32'd1);
      chk("d40_pc",   pc_out, 32'h40);
      chk("d40_inst", instruccion, 32'h140);

      // Redirect plus ack while stalled with a full skid.
      stall = 1'b1;
      step();
      chk("fl_req", 32'(imem_if.imem_req), 32'd0);
      chk("fl_pc",  pc_out, 32'h40);
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      zw          = 1'b0;
      man_ack     = 1'b1;
      step();
      chk("rf_val",  32'(inst_valid), 32'd0);
      chk("rf_addr", imem_if.imem_addr, 32'h80);
      chk("rf_req",  32'(imem_if.imem_req), 32'd1);
      redirect = 1'b0;
      man_ack  = 1'b0;
      zw       = 1'b1;
      stall    = 1'b0;
      step();
      chk("rf2_pc",   pc_out, 32'h80);
      chk("rf2_inst", instruccion, 32'h180);
      step();
      chk("rf3_pc", pc_out, 32'h84);

      // Reset during an outstanding delayed request; ack during/after reset ignored.
      zw = 1'b0;
      step();
      chk("pr_addr", imem_if.imem_addr, 32'h88);
      chk("pr_val",  32'(inst_valid), 32'd0);
      rst_n   = 1'b0;
      man_ack = 1'b1;
      step();
      chk("mr_req",   32'(imem_if.imem_req), 32'd0);
      chk("mr_addr",  imem_if.imem_addr, 32'h0);
      chk("mr_val",   32'(inst_valid), 32'd0);
      chk("mr_pc",    pc_out, 32'h0);
      chk("mr_inst",  instruccion, 32'h0);
      rst_n = 1'b1;
      step();
      chk("late_val",  32'(inst_valid), 32'd0);
      chk("late_req",  32'(imem_if.imem_req), 32'd1);
      chk("late_addr", imem_if.imem_addr, 32'h0);
      man_ack = 1'b0;
      zw      = 1'b1;
      step();
      chk("rs_val",  32'(inst_valid), 32'd1);
      chk("rs_pc",   pc_out, 32'h0);
      chk("rs_inst", instruccion, 32'h100);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
